control_estacionamiento: RTL

//   Parametrised parking-lot occupancy controller. Successor to the fixed 8-slot counter.

---
 rtl/control_estacionamiento.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/control_estacionamiento.sv
// control_estacionamiento: parking-lot occupancy controller.
// Debounced entry/exit sensing, saturating count and a timed entry barrier.
module control_estacionamiento_filtro #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic ev_o
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic          s1_q;
  logic          s2_q;
  logic          filt_q;
  logic          filt_d;
  logic          filt_dly_q;
  logic          ev_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Filtered level flips on the DEBOUNCE-th consecutive disagreeing sample.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == DW'(DEBOUNCE - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
      ev_q       <= 1'b0;
    end else begin
      s1_q       <= raw_i;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      filt_dly_q <= filt_q;
      ev_q       <= filt_q & ~filt_dly_q;
    end
  end

  assign ev_o = ev_q;

endmodule

module control_estacionamiento #(
  parameter  int CAPACIDAD   = 8,
  parameter  int UMBRAL_CASI = 6,
  parameter  int DEBOUNCE    = 4,
  parameter  int T_BARRERA   = 16,
  localparam int CW          = $clog2(CAPACIDAD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          auto_entra,
  input  logic          auto_sale,
  output logic [CW-1:0] count,
  output logic          lleno,
  output logic          vacio,
  output logic          casi_lleno,
  output logic          barrera_abierta,
  output logic          rechazo,
  output logic          error_sale,
  output logic [7:0]    total_rechazos
);

  localparam int TW = (T_BARRERA > 1) ? $clog2(T_BARRERA) : 1;

  typedef enum logic {
    ESPERA,
    ABIERTA
  } estado_t;

  logic          ev_entra;
  logic          ev_sale;
  logic          sal_ok;
  logic          ent_ok;
  logic          rech_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          lleno_q;
  logic          vacio_q;
  logic          casi_q;
  logic          rech_q;
  logic          err_q;
  logic [7:0]    tot_q;
  estado_t       est_q;
  logic [TW-1:0] tmr_q;
  logic          bar_q;

  control_estacionamiento_filtro #(
    .DEBOUNCE (DEBOUNCE)
  ) u_f_entra (
    .clk   (clk),
    .reset (reset),
    .raw_i (auto_entra),
    .ev_o  (ev_entra)
  );

  control_estacionamiento_filtro #(
    .DEBOUNCE (DEBOUNCE)
  ) u_f_sale (
    .clk   (clk),
    .reset (reset),
    .raw_i (auto_sale),
    .ev_o  (ev_sale)
  );

  // An exit frees a slot in the same cycle, so a full lot can still accept.
  always_comb begin
    sal_ok  = ev_sale && (count_q != '0);
    ent_ok  = ev_entra && ((count_q < CW'(CAPACIDAD)) || sal_ok);
    rech_d  = ev_entra && !ent_ok;
    count_d = count_q;
    unique case (1'b1)
      (ent_ok && !sal_ok): count_d = count_q + 1'b1;
      (sal_ok && !ent_ok): count_d = count_q - 1'b1;
      default:             count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      lleno_q <= 1'b0;
      vacio_q <= 1'b1;
      casi_q  <= (UMBRAL_CASI == 0);
      rech_q  <= 1'b0;
      err_q   <= 1'b0;
      tot_q   <= '0;
    end else begin
      count_q <= count_d;
      lleno_q <= (count_d == CW'(CAPACIDAD));
      vacio_q <= (count_d == '0);
      casi_q  <= (count_d >= CW'(UMBRAL_CASI));
      rech_q  <= rech_d;
      err_q   <= ev_sale && (count_q == '0);
      if (rech_d && (tot_q != 8'hFF)) begin
        tot_q <= tot_q + 8'd1;
      end
    end
  end

  // Barrier stays open T_BARRERA cycles after the latest accepted entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      est_q <= ESPERA;
      tmr_q <= '0;
      bar_q <= 1'b0;
    end else begin
      unique case (est_q)
        ESPERA: begin
          if (ent_ok) begin
            est_q <= ABIERTA;
            tmr_q <= TW'(T_BARRERA - 1);
            bar_q <= 1'b1;
          end
        end
        ABIERTA: begin
          if (ent_ok) begin
            tmr_q <= TW'(T_BARRERA - 1);
          end else if (tmr_q == '0) begin
            est_q <= ESPERA;
            bar_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          est_q <= ESPERA;
          bar_q <= 1'b0;
        end
      endcase
    end
  end

  assign count           = count_q;
  assign lleno           = lleno_q;
  assign vacio           = vacio_q;
  assign casi_lleno      = casi_q;
  assign barrera_abierta = bar_q;
  assign rechazo         = rech_q;
  assign error_sale      = err_q;
  assign total_rechazos  = tot_q;

endmodule
